// File: rtl/ram_port_controller.sv
// Sequencer in front of a single-port RAM with a shared tri-state data bus.
// Issues setup/pulse/hold/turnaround strobes, returns read data and runs a fill sweep.
module ram_port_controller #(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 9,
  parameter int                WAIT_CYCLES = 1,
  parameter logic [DATA_W-1:0] INIT_VALUE  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic              init_start,
  output logic              init_busy,
  output logic              init_done,
  output logic              ram_re,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [DATA_W-1:0] ram_data
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CW    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int SW    = ADDR_W + 1;

  typedef enum logic [2:0] {
    IDLE, W_SETUP, W_PULSE, W_HOLD, R_SETUP, R_PULSE, R_TURN
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     wait_q, wait_d;
  logic [SW-1:0]     sweep_q, sweep_d;
  logic [SW-1:0]     sweep_inc;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              drive_q, drive_d;
  logic              re_q, re_d;
  logic              we_q, we_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_write_q, rsp_write_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pulse_last;
  logic              accept;

  // A simultaneous init_start takes priority, so the request is refused that cycle.
  assign req_ready  = (state_q == IDLE) && !busy_q && !init_start && !rst;
  assign accept     = req_valid && req_ready;
  assign pulse_last = (wait_q == CW'(WAIT_CYCLES - 1));
  assign sweep_inc  = sweep_q + SW'(1);

  always_comb begin
    state_d     = state_q;
    wait_d      = '0;
    sweep_d     = sweep_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;
    rsp_write_d = rsp_write_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (init_start && !busy_q) begin
          busy_d  = 1'b1;
          sweep_d = '0;
          addr_d  = '0;
          wdata_d = INIT_VALUE;
          state_d = W_SETUP;
        end else if (accept) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (req_write) state_d = W_SETUP;
          else           state_d = R_SETUP;
        end
      end
      W_SETUP: state_d = W_PULSE;
      W_PULSE: begin
        if (pulse_last) state_d = W_HOLD;
        else            wait_d  = wait_q + CW'(1);
      end
      W_HOLD: begin
        if (busy_q) begin
          // The counter is one bit wider than the address so the end is seen without wrapping.
          sweep_d = sweep_inc;
          if (sweep_inc == SW'(DEPTH)) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            addr_d  = sweep_inc[ADDR_W-1:0];
            state_d = W_SETUP;
          end
        end else begin
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b1;
          state_d     = IDLE;
        end
      end
      R_SETUP: state_d = R_PULSE;
      R_PULSE: begin
        if (pulse_last) begin
          rdata_d = ram_data;
          state_d = R_TURN;
        end else begin
          wait_d = wait_q + CW'(1);
        end
      end
      R_TURN: begin
        rsp_valid_d = 1'b1;
        rsp_write_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Strobes and bus enable follow the next state so they are registered yet aligned with it.
    re_d    = (state_d == R_PULSE);
    we_d    = (state_d == W_PULSE);
    drive_d = (state_d == W_SETUP) || (state_d == W_PULSE) || (state_d == W_HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      sweep_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      drive_q     <= 1'b0;
      re_q        <= 1'b0;
      we_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      sweep_q     <= sweep_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      drive_q     <= drive_d;
      re_q        <= re_d;
      we_q        <= we_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign ram_data  = drive_q ? wdata_q : 'z;
  assign ram_re    = re_q;
  assign ram_we    = we_q;
  assign ram_addr  = addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rdata_q;
  assign init_busy = busy_q;
  assign init_done = done_q;

endmodule
